fft_mag_squared: RTL and testbench
==================================

FFT_MAG_SQUARED -- requirements
Module: fft_mag_squared

Interface
REQ-001 SHALL have parameter IN_W, default 24, width of each signed real/imag component.
REQ-002 SHALL have parameter FRAME_LEN, default 1024, bins per FFT frame (power of two, 4..4096).
REQ-003 SHALL have parameter LATENCY, fixed 3, pipeline depth from accepted input beat to output beat.
REQ-004 clk  input  1  clock, all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_data  input  2*IN_W  FFT output bin; [IN_W-1:0] real, [2*IN_W-1:IN_W] imag, two's complement.
REQ-007 s_valid  input  1  input beat valid.
REQ-008 s_last  input  1  marks final bin of FFT frame.
REQ-009 s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-010 m_data  output  2*IN_W  unsigned re^2 + im^2.
REQ-011 m_valid  output  1  output beat valid.
REQ-012 m_last  output  1  final bin of frame, qualified by m_valid.
REQ-013 m_bin  output  log2(FRAME_LEN)  bin index of m_data, qualified by m_valid.
REQ-014 m_ready  input  1  downstream accepts beat (fundamental bin finder ties high).
REQ-015 frame_err  output  1  one-cycle pulse on frame-length mismatch.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 registers re/im, S2 registers re*re and im*im (signed, 2*IN_W bits each), S3 registers unsigned sum.
REQ-017 Sum SHALL be exact: max operands (-2^(IN_W-1))^2 give 2^(2*IN_W-1), fitting 2*IN_W bits with no overflow or truncation.
REQ-018 Each stage SHALL carry a valid bit, last bit and bin index alongside data.
REQ-019 Pipeline advance enable SHALL be adv = !m_valid || m_ready; all stages shift only when adv is high.
REQ-020 s_ready SHALL equal adv; bubbles (invalid stages) SHALL still shift when adv is high.
REQ-021 With m_ready held high, the beat accepted at cycle t SHALL appear on m_data at cycle t+3; throughput one beat per cycle.
REQ-022 While m_valid && !m_ready, m_data, m_valid, m_last, m_bin SHALL hold stable and no input beat SHALL be accepted.
REQ-023 Bin counter SHALL increment on each accepted input beat, tag that beat, and wrap from FRAME_LEN-1 to 0.
REQ-024 Accepted beat with s_last SHALL set the counter to 0 for the next beat regardless of its current value.
REQ-025 Simultaneous counter wrap and s_last SHALL produce a single reset to 0, not an error.

Reset
REQ-026 On reset all stage valid bits, m_valid, m_last, m_bin, m_data, frame_err and the bin counter SHALL be 0.
REQ-027 Reset mid-frame SHALL discard all in-flight beats; first beat after reset SHALL be tagged bin 0.
REQ-028 s_ready SHALL be 1 in the cycle following reset deassertion.

Configuration
REQ-029 With macro FFT_MAG_FRAME_CHECK_EN defined: frame_err SHALL pulse one cycle, aligned with the output beat, when s_last arrives on a bin != FRAME_LEN-1 or bin FRAME_LEN-1 arrives without s_last; m_last SHALL be asserted on bin FRAME_LEN-1 or s_last-tagged beats.
REQ-030 Without FFT_MAG_FRAME_CHECK_EN: frame_err SHALL be tied 0, m_last SHALL be s_last delayed through the pipeline, counter behaviour per REQ-023..025 unchanged.

Verification
REQ-031 Reset, then re=3, im=-4 with m_ready=1 -> m_data=25, m_bin=0, m_valid exactly 3 cycles after acceptance.
REQ-032 re=im=-8388608 (IN_W=24) -> m_data=0x800000000000, no overflow.
REQ-033 1024 back-to-back beats, s_last on last, m_ready=1 -> m_bin 0..1023 contiguous, m_last only on bin 1023, frame_err never set.
REQ-034 Stream with m_ready randomly low 50% -> no loss/duplication, outputs stable while stalled, s_ready=0 whenever m_valid && !m_ready.
REQ-035 FFT_MAG_FRAME_CHECK_EN defined, s_last on bin 500 -> frame_err pulses with bin-500 output, next beat tagged bin 0; missing s_last on bin 1023 -> frame_err pulse, next bin 0.
REQ-036 Assert reset at bin 300 with 3 beats in flight -> no further m_valid from old frame, next accepted beat m_bin=0.

Source files
------------

// File: rtl/fft_mag_squared_if.sv
// Stream bundle for fft_mag_squared: complex FFT bins in, unsigned power
// out with bin index and frame markers. slave = the block, master = its peers.
interface fft_mag_squared_if #(
  parameter int IN_W      = 24,
  parameter int FRAME_LEN = 1024
);
  localparam int BIN_W = $clog2(FRAME_LEN);

  logic [2*IN_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [2*IN_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic [BIN_W-1:0]  m_bin;
  logic              m_ready;
  logic              frame_err;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_bin, frame_err
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_bin, frame_err
  );
endinterface

// File: rtl/fft_mag_squared.sv
// Three-stage re^2 + im^2 power pipeline with bin tagging and backpressure.
// Define FFT_MAG_FRAME_CHECK_EN to enable frame-length checking on frame_err.
module fft_mag_squared #(
  parameter int IN_W      = 24,
  parameter int FRAME_LEN = 1024,
  parameter int LATENCY   = 3
) (
  input logic             clk,
  input logic             reset,
  fft_mag_squared_if.slave bus
);
  localparam int PROD_W = 2 * IN_W;
  localparam int BIN_W  = $clog2(FRAME_LEN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  generate
    if (LATENCY != 3) begin : g_latency_check
      $error("fft_mag_squared: LATENCY is fixed at 3");
    end
  endgenerate

  logic                     adv;
  logic                     accept;
  logic                     at_end;
  logic                     beat_last;
  logic [BIN_W-1:0]         bin_cnt;

  logic                     v1, last1;
  logic [BIN_W-1:0]         bin1;
  logic signed [IN_W-1:0]   re1, im1;

  logic                     v2, last2;
  logic [BIN_W-1:0]         bin2;
  logic signed [PROD_W-1:0] sq_re, sq_im;

  logic                     v3, last3;
  logic [BIN_W-1:0]         bin3;
  logic [PROD_W-1:0]        data3;

  // Everything moves together whenever the output slot is free or being taken.
  assign adv    = !v3 || bus.m_ready;
  assign accept = bus.s_valid && adv;
  assign at_end = (bin_cnt == LAST_BIN);

`ifdef FFT_MAG_FRAME_CHECK_EN
  logic beat_err;
  logic err1, err2, err3;

  assign beat_last = bus.s_last || at_end;
  assign beat_err  = bus.s_last != at_end;
`else
  assign beat_last = bus.s_last;
`endif

  // A frame ends on s_last or on the final bin; both just restart at bin 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt <= '0;
    end else if (accept) begin
      if (bus.s_last || at_end) begin
        bin_cnt <= '0;
      end else begin
        bin_cnt <= bin_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      bin1  <= '0;
      re1   <= '0;
      im1   <= '0;
      v2    <= 1'b0;
      last2 <= 1'b0;
      bin2  <= '0;
      sq_re <= '0;
      sq_im <= '0;
      v3    <= 1'b0;
      last3 <= 1'b0;
      bin3  <= '0;
      data3 <= '0;
    end else if (adv) begin
      v1    <= accept;
      last1 <= accept && beat_last;
      bin1  <= bin_cnt;
      re1   <= bus.s_data[IN_W-1:0];
      im1   <= bus.s_data[2*IN_W-1:IN_W];

      // Full-width signed squares; the worst case (-2^(IN_W-1))^2 still fits.
      v2    <= v1;
      last2 <= last1;
      bin2  <= bin1;
      sq_re <= PROD_W'(re1) * PROD_W'(re1);
      sq_im <= PROD_W'(im1) * PROD_W'(im1);

      v3    <= v2;
      last3 <= last2;
      bin3  <= bin2;
      data3 <= $unsigned(sq_re) + $unsigned(sq_im);
    end
  end

`ifdef FFT_MAG_FRAME_CHECK_EN
  // The error pulse fires only on the cycle its beat first appears at the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      err1 <= 1'b0;
      err2 <= 1'b0;
      err3 <= 1'b0;
    end else if (adv) begin
      err1 <= accept && beat_err;
      err2 <= err1;
      err3 <= v2 && err2;
    end else begin
      err3 <= 1'b0;
    end
  end

  assign bus.frame_err = err3;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.s_ready = adv;
  assign bus.m_valid = v3;
  assign bus.m_last  = last3;
  assign bus.m_bin   = bin3;
  assign bus.m_data  = data3;
endmodule

// File: tb/tb_fft_mag_squared.sv
// Directed bench for fft_mag_squared: expected beats go into a queue and a
// monitor compares every output beat, stall behaviour and s_ready each cycle.
module tb_fft_mag_squared;
  localparam int IN_W      = 24;
  localparam int FRAME_LEN = 1024;
  localparam int BIN_W     = $clog2(FRAME_LEN);
`ifdef FFT_MAG_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [2*IN_W-1:0] data;
    logic [BIN_W-1:0]  bin;
    logic              last;
    logic              err;
  } exp_t;

  logic clk;
  logic reset;
  bit   rand_ready;
  int   checks;
  int   errors;
  int   exp_bin;
  exp_t exp_q[$];

  fft_mag_squared_if #(.IN_W(IN_W), .FRAME_LEN(FRAME_LEN)) bus ();

  fft_mag_squared #(.IN_W(IN_W), .FRAME_LEN(FRAME_LEN), .LATENCY(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [2*IN_W-1:0] sqSum(input longint re, input longint im);
    longint s;
    s = re * re + im * im;
    return s[2*IN_W-1:0];
  endfunction

  // Drives one beat, holding it until accepted, and queues what should come out.
  task automatic applyStimulus(input logic signed [IN_W-1:0] re, input logic signed [IN_W-1:0] im,
                               input bit last, input logic [2*IN_W-1:0] exp_data);
    exp_t e;
    bit   accepted;
    bit   at_end;
    int   n;
    accepted    = 1'b0;
    n           = 0;
    bus.s_data  = {im, re};
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    while (!accepted && n < 1000) begin
      @(negedge clk);
      if (bus.s_ready) begin
        at_end  = (exp_bin == FRAME_LEN - 1);
        e.data  = exp_data;
        e.bin   = BIN_W'(exp_bin);
        e.last  = CHECK_EN ? (last || at_end) : last;
        e.err   = CHECK_EN && (last != at_end);
        exp_q.push_back(e);
        exp_bin = (last || at_end) ? 0 : exp_bin + 1;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Each output beat is compared against the queue head for as long as it is shown.
  initial begin
    exp_t e;
    bit   held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        checkOutput("s_ready", 64'(bus.s_ready), 64'(!(bus.m_valid && !bus.m_ready)));
        if (bus.m_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q[0];
            checkOutput("m_data", 64'(bus.m_data), 64'(e.data));
            checkOutput("m_bin", 64'(bus.m_bin), 64'(e.bin));
            checkOutput("m_last", 64'(bus.m_last), 64'(e.last));
            checkOutput("frame_err", 64'(bus.frame_err), held ? 64'd0 : 64'(e.err));
            if (bus.m_ready) void'(exp_q.pop_front());
          end
        end else begin
          checkOutput("frame_err_idle", 64'(bus.frame_err), 64'd0);
        end
        held = bus.m_valid && !bus.m_ready;
      end
    end
  end

  initial begin
    int cycles;
    int stale;
    checks      = 0;
    errors      = 0;
    exp_bin     = 0;
    rand_ready  = 1'b0;
    reset       = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("rst_m_data", 64'(bus.m_data), 64'd0);
    checkOutput("rst_m_bin", 64'(bus.m_bin), 64'd0);
    checkOutput("rst_m_last", 64'(bus.m_last), 64'd0);
    checkOutput("rst_frame_err", 64'(bus.frame_err), 64'd0);
    checkOutput("rst_s_ready", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;

    // 3 - 4j -> 9 + 16, three cycles after acceptance
    applyStimulus(24'sd3, -24'sd4, 1'b0, 48'd25);
    cycles = 1;
    while (cycles < 20) begin
      @(negedge clk);
      if (bus.m_valid) break;
      @(posedge clk);
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'd3);
    checkOutput("first_data", 64'(bus.m_data), 64'd25);
    checkOutput("first_bin", 64'(bus.m_bin), 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(-24'sd8388608, -24'sd8388608, 1'b0, 48'h8000_0000_0000);
    applyStimulus(24'sd8388607, 24'sd8388607, 1'b0, 48'h7FFF_FE00_0002);
    applyStimulus(-24'sd1, 24'sd0, 1'b0, 48'd1);
    applyStimulus(24'sd0, -24'sd8388608, 1'b1, 48'h4000_0000_0000);
    waitDrain();

    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(24'(i), 24'(i - 512), (i == FRAME_LEN - 1), sqSum(i, i - 512));
    end
    waitDrain();

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(24'(i * 40503 - 4000000), 24'(3000000 - i * 27011), (i == 199),
                    sqSum(i * 40503 - 4000000, 3000000 - i * 27011));
    end
    waitDrain();
    rand_ready = 1'b0;

    // Short frame ending on bin 500, then a frame missing its s_last.
    for (int i = 0; i <= 500; i++) begin
      applyStimulus(24'(-i), 24'(7), (i == 500), sqSum(-i, 7));
    end
    for (int i = 0; i <= FRAME_LEN; i++) begin
      applyStimulus(24'(i * 3), 24'(-2), 1'b0, sqSum(i * 3, -2));
    end
    waitDrain();
    checkOutput("model_bin_after_wrap", 64'(exp_bin), 64'd1);
    applyStimulus(24'sd1, 24'sd1, 1'b1, 48'd2);
    waitDrain();

    // Reset in the middle of a frame with beats still in the pipeline.
    for (int i = 0; i <= 302; i++) begin
      applyStimulus(24'(i), 24'(i), 1'b0, sqSum(i, i));
    end
    reset = 1'b1;
    exp_q.delete();
    exp_bin = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m_valid) stale++;
    end
    checkOutput("stale_valid_after_reset", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(24'sd5, 24'sd12, 1'b0, 48'd169);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
